// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: FSM state encoding,
// opcode/function constants, I/O-decode defaults and the decode bundle.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam int IO_HIGH_W_DEF = 22;
    localparam int MEM_LAT_DEF   = 1;

    // Decoded instruction class plus datapath controls.
    typedef struct packed {
        logic       is_r;
        logic       is_i;
        logic       is_lw;
        logic       is_sw;
        logic       is_beq;
        logic       is_bne;
        logic       is_jal;
        logic       is_j;
        logic       jr;
        logic       sftmd;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } dec_t;

    // Shift-type R-format function codes (sll, srl, sra, sllv, srlv, srav).
    function automatic logic is_shift_func(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational decode of the registered op/func fields.
module instr_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output dec_t       dec
);

    // Classify the instruction and derive the static datapath controls.
    always_comb begin
        dec         = '0;
        dec.is_r    = (op == OP_RTYPE);
        dec.is_i    = (op[5:3] == 3'b001);
        dec.is_lw   = (op == OP_LW);
        dec.is_sw   = (op == OP_SW);
        dec.is_beq  = (op == OP_BEQ);
        dec.is_bne  = (op == OP_BNE);
        dec.is_jal  = (op == OP_JAL);
        dec.is_j    = (op == OP_J);
        dec.jr      = dec.is_r & (func == FN_JR);
        dec.sftmd   = dec.is_r & is_shift_func(func);
        dec.alu_src = ~dec.is_r;
        dec.reg_dst = dec.is_r;
        dec.alu_op  = {dec.is_r | dec.is_i, dec.is_beq | dec.is_bne};
    end

endmodule

// File: rtl/mc_control32.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// fixed-latency memory path and a handshake-terminated I/O path.
module mc_control32
    import mc_ctrl_pkg::*;
#(
    parameter int                   IO_HIGH_W   = IO_HIGH_W_DEF,
    parameter logic [IO_HIGH_W-1:0] IO_HIGH_VAL = {IO_HIGH_W{1'b1}},
    parameter int                   MEM_LAT     = MEM_LAT_DEF
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           func,
    input  logic [IO_HIGH_W-1:0] alu_result_high,
    input  logic                 io_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic [1:0]           alu_op,
    output logic                 jr,
    output logic                 jal,
    output logic                 branch,
    output logic                 nbranch,
    output logic                 reg_dst,
    output logic                 alu_src,
    output logic                 sftmd,
    output logic                 reg_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 io_read,
    output logic                 io_write,
    output logic                 mem_or_io_to_reg,
    output logic [2:0]           state,
    output logic                 busy
);

    localparam logic [3:0] MEM_LAT_C = 4'(MEM_LAT);

    state_e     state_r, state_nxt_s;
    logic [5:0] op_r, func_r;
    logic [3:0] cnt_r;
    logic       is_io_r;
    dec_t       dec_s;

    logic latch_op_s, load_mem_s, mem_last_s;
    logic pc_write_s, ir_write_s, reg_write_s, m2r_s;
    logic mem_read_s, mem_write_s, io_read_s, io_write_s;

    instr_decode u_decode (
        .op   (op_r),
        .func (func_r),
        .dec  (dec_s)
    );

    // Next-state logic and per-phase strobes.
    always_comb begin
        state_nxt_s = ST_FETCH;
        latch_op_s  = 1'b0;
        load_mem_s  = 1'b0;
        mem_last_s  = 1'b0;
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        m2r_s       = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        io_read_s   = 1'b0;
        io_write_s  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                ir_write_s  = 1'b1;
                state_nxt_s = ST_DECODE;
            end
            ST_DECODE: begin
                latch_op_s  = 1'b1;
                state_nxt_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_s.is_lw || dec_s.is_sw) begin
                    load_mem_s  = 1'b1;
                    state_nxt_s = ST_MEM;
                end else if ((dec_s.is_r && !dec_s.jr) || dec_s.is_i || dec_s.is_jal) begin
                    state_nxt_s = ST_WB;
                end else begin
                    // Branches, jumps, jr and unknown ops retire here.
                    pc_write_s  = 1'b1;
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (is_io_r) begin
                    io_read_s  = dec_s.is_lw;
                    io_write_s = dec_s.is_sw;
                    mem_last_s = io_ready;
                end else begin
                    mem_read_s  = dec_s.is_lw;
                    mem_write_s = dec_s.is_sw;
                    // A zero count can only follow a bad load; leave rather than stall.
                    mem_last_s  = (cnt_r <= 4'd1);
                end
                if (!mem_last_s) begin
                    state_nxt_s = ST_MEM;
                end else if (dec_s.is_sw) begin
                    pc_write_s  = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            ST_WB: begin
                reg_write_s = 1'b1;
                pc_write_s  = 1'b1;
                m2r_s       = dec_s.is_lw;
                state_nxt_s = ST_FETCH;
            end
            default: begin
                state_nxt_s = ST_FETCH;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Instruction field capture in DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r   <= 6'd0;
            func_r <= 6'd0;
        end else if (latch_op_s) begin
            op_r   <= op;
            func_r <= func;
        end
    end

    // Memory-latency down-counter and I/O-space flag, loaded on EXEC->MEM.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= 4'd0;
            is_io_r <= 1'b0;
        end else if (load_mem_s) begin
            cnt_r   <= MEM_LAT_C;
            is_io_r <= (alu_result_high == IO_HIGH_VAL);
        end else if ((state_r == ST_MEM) && !is_io_r && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Outputs are forced low during a reset cycle so an in-flight access is dropped at once.
    assign pc_write         = pc_write_s  & ~reset;
    assign ir_write         = ir_write_s  & ~reset;
    assign reg_write        = reg_write_s & ~reset;
    assign mem_or_io_to_reg = m2r_s       & ~reset;
    assign mem_read         = mem_read_s  & ~reset;
    assign mem_write        = mem_write_s & ~reset;
    assign io_read          = io_read_s   & ~reset;
    assign io_write         = io_write_s  & ~reset;
    assign alu_op           = dec_s.alu_op & {2{~reset}};
    assign jr               = dec_s.jr      & ~reset;
    assign jal              = dec_s.is_jal  & ~reset;
    assign branch           = dec_s.is_beq  & ~reset;
    assign nbranch          = dec_s.is_bne  & ~reset;
    assign reg_dst          = dec_s.reg_dst & ~reset;
    assign alu_src          = dec_s.alu_src & ~reset;
    assign sftmd            = dec_s.sftmd   & ~reset;
    assign state            = reset ? 3'd0 : state_r;
    assign busy             = ~reset & (state_r != ST_FETCH);

endmodule

// File: tb/tb_mc_control32.sv
// Directed bench for mc_control32: per-instruction vector table plus
// hand-written reset and state-trace sequences.
module tb_mc_control32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = 6'd0;
    logic [5:0]  func = 6'd0;
    logic [21:0] ahi = 22'd0;
    logic        io_ready = 1'b0;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic [1:0] alu_op;
        logic       jr;
        logic       jal;
        logic       branch;
        logic       nbranch;
        logic       reg_dst;
        logic       alu_src;
        logic       sftmd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       io_read;
        logic       io_write;
        logic       m2r;
        logic [2:0] state;
        logic       busy;
    } obs_t;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  func;
        logic [21:0] ahi;
        int          io_wait;
        bit          fpulse;
        int          cycles;
        int          regw;
        int          pcw;
        int          mrd;
        int          mwr;
        int          ird;
        int          iwr;
        int          m2r;
        logic [8:0]  dec;   // {reg_dst, alu_src, alu_op, jr, sftmd, branch, nbranch, jal}
    } vec_t;

    obs_t obs3, obs4, cur;
    bit   sel = 1'b0;
    int   errs = 0;
    int   checks = 0;
    vec_t vecs[15];

    logic a_pcw, a_irw, a_jr, a_jal, a_br, a_nbr, a_rd, a_src, a_sft, a_rw, a_mr, a_mw, a_ir, a_iw, a_m2r, a_busy;
    logic [1:0] a_aop;
    logic [2:0] a_st;
    logic b_pcw, b_irw, b_jr, b_jal, b_br, b_nbr, b_rd, b_src, b_sft, b_rw, b_mr, b_mw, b_ir, b_iw, b_m2r, b_busy;
    logic [1:0] b_aop;
    logic [2:0] b_st;

    mc_control32 #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .op(op), .func(func), .alu_result_high(ahi), .io_ready(io_ready),
        .pc_write(a_pcw), .ir_write(a_irw), .alu_op(a_aop), .jr(a_jr), .jal(a_jal), .branch(a_br),
        .nbranch(a_nbr), .reg_dst(a_rd), .alu_src(a_src), .sftmd(a_sft), .reg_write(a_rw),
        .mem_read(a_mr), .mem_write(a_mw), .io_read(a_ir), .io_write(a_iw), .mem_or_io_to_reg(a_m2r),
        .state(a_st), .busy(a_busy)
    );

    mc_control32 #(.MEM_LAT(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .func(func), .alu_result_high(ahi), .io_ready(io_ready),
        .pc_write(b_pcw), .ir_write(b_irw), .alu_op(b_aop), .jr(b_jr), .jal(b_jal), .branch(b_br),
        .nbranch(b_nbr), .reg_dst(b_rd), .alu_src(b_src), .sftmd(b_sft), .reg_write(b_rw),
        .mem_read(b_mr), .mem_write(b_mw), .io_read(b_ir), .io_write(b_iw), .mem_or_io_to_reg(b_m2r),
        .state(b_st), .busy(b_busy)
    );

    assign obs3 = {a_pcw, a_irw, a_aop, a_jr, a_jal, a_br, a_nbr, a_rd, a_src, a_sft, a_rw,
                   a_mr, a_mw, a_ir, a_iw, a_m2r, a_st, a_busy};
    assign obs4 = {b_pcw, b_irw, b_aop, b_jr, b_jal, b_br, b_nbr, b_rd, b_src, b_sft, b_rw,
                   b_mr, b_mw, b_ir, b_iw, b_m2r, b_st, b_busy};
    assign cur  = sel ? obs4 : obs3;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Two reset edges; both DUTs must show all-zero outputs during reset.
    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        io_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_outputs_dut3", int'(obs3), 0);
        chk("reset_outputs_dut4", int'(obs4), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Run one instruction from its FETCH cycle to the next FETCH and compare tallies.
    task automatic run_instr(input int idx, input vec_t v);
        int n = 0, mem_n = 0, regw = 0, pcw = 0, mrd = 0, mwr = 0, ird = 0, iwr = 0;
        int m2r = 0, irw = 0, multi = 0, pcw_idx = -1, regw_idx = -1;
        logic [8:0] dec_last = 9'd0;
        bit done = 1'b0;
        string tag;
        tag  = $sformatf("vec%0d", idx);
        op   = v.op;
        func = v.func;
        ahi  = v.ahi;
        while (!done && n < 40) begin
            #1;
            if (n > 0 && cur.state == 3'd0) begin
                done     = 1'b1;
                io_ready = 1'b0;
            end else begin
                io_ready = ((cur.state == 3'd0) && v.fpulse) ||
                           ((cur.state == 3'd3) && (mem_n >= v.io_wait));
                #1;
                if (cur.pc_write)  begin pcw++;  pcw_idx = n;  end
                if (cur.reg_write) begin regw++; regw_idx = n; end
                mrd += int'(cur.mem_read);
                mwr += int'(cur.mem_write);
                ird += int'(cur.io_read);
                iwr += int'(cur.io_write);
                m2r += int'(cur.m2r);
                irw += int'(cur.ir_write);
                if ((int'(cur.mem_read) + int'(cur.mem_write) + int'(cur.io_read) + int'(cur.io_write)) > 1)
                    multi++;
                if (cur.state == 3'd3) mem_n++;
                dec_last = {cur.reg_dst, cur.alu_src, cur.alu_op, cur.jr, cur.sftmd,
                            cur.branch, cur.nbranch, cur.jal};
                n++;
                @(negedge clk);
            end
        end
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_cycles"}, n, v.cycles);
        chk({tag, "_reg_write"}, regw, v.regw);
        chk({tag, "_pc_write"}, pcw, v.pcw);
        chk({tag, "_pc_write_last"}, pcw_idx, v.cycles - 1);
        if (v.regw > 0) chk({tag, "_reg_write_last"}, regw_idx, v.cycles - 1);
        chk({tag, "_mem_read"}, mrd, v.mrd);
        chk({tag, "_mem_write"}, mwr, v.mwr);
        chk({tag, "_io_read"}, ird, v.ird);
        chk({tag, "_io_write"}, iwr, v.iwr);
        chk({tag, "_m2r"}, m2r, v.m2r);
        chk({tag, "_ir_write"}, irw, 1);
        chk({tag, "_onehot"}, multi, 0);
        chk({tag, "_decode"}, int'(dec_last), int'(v.dec));
    endtask

    initial begin
        int exp_st[5];
        //           op     func   ahi          wait fp cyc rw pw mr mw ir iw m2r dec
        vecs[0]  = '{6'h00, 6'h20, 22'h000001,  0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 9'b1_0_10_0_0_0_0_0}; // add
        vecs[1]  = '{6'h23, 6'h00, 22'h000001,  0, 0, 7, 1, 1, 3, 0, 0, 0, 1, 9'b0_1_00_0_0_0_0_0}; // lw mem
        vecs[2]  = '{6'h2B, 6'h00, 22'h3FFFFF,  5, 0, 9, 0, 1, 0, 0, 0, 6, 0, 9'b0_1_00_0_0_0_0_0}; // sw io
        vecs[3]  = '{6'h00, 6'h08, 22'h000000,  0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 9'b1_0_10_1_0_0_0_0}; // jr
        vecs[4]  = '{6'h05, 6'h00, 22'h000000,  0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 9'b0_1_01_0_0_0_1_0}; // bne
        vecs[5]  = '{6'h3F, 6'h00, 22'h3FFFFF,  0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 9'b0_1_00_0_0_0_0_0}; // unknown
        vecs[6]  = '{6'h2B, 6'h00, 22'h000000,  0, 0, 6, 0, 1, 0, 3, 0, 0, 0, 9'b0_1_00_0_0_0_0_0}; // sw mem
        vecs[7]  = '{6'h23, 6'h00, 22'h3FFFFF,  2, 0, 7, 1, 1, 0, 0, 3, 0, 1, 9'b0_1_00_0_0_0_0_0}; // lw io
        vecs[8]  = '{6'h00, 6'h00, 22'h000000,  0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 9'b1_0_10_0_1_0_0_0}; // sll
        vecs[9]  = '{6'h08, 6'h00, 22'h000000,  0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 9'b0_1_10_0_0_0_0_0}; // addi
        vecs[10] = '{6'h03, 6'h00, 22'h000000,  0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 9'b0_1_00_0_0_0_0_1}; // jal
        vecs[11] = '{6'h04, 6'h00, 22'h000000,  0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 9'b0_1_01_0_0_1_0_0}; // beq
        vecs[12] = '{6'h02, 6'h00, 22'h000000,  0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 9'b0_1_00_0_0_0_0_0}; // j
        vecs[13] = '{6'h23, 6'h00, 22'h3FFFFE,  0, 0, 7, 1, 1, 3, 0, 0, 0, 1, 9'b0_1_00_0_0_0_0_0}; // lw near-io
        vecs[14] = '{6'h2B, 6'h00, 22'h3FFFFF,  0, 0, 4, 0, 1, 0, 0, 0, 1, 0, 9'b0_1_00_0_0_0_0_0}; // sw io fast

        // Table-driven run on the MEM_LAT=3 instance.
        sel = 1'b0;
        for (int i = 0; i < 15; i++) begin
            do_reset();
            run_instr(i, vecs[i]);
        end

        // add state trace: 0,1,2,4,0 with strobes only in WB.
        exp_st = '{0, 1, 2, 4, 0};
        do_reset();
        op   = 6'h00;
        func = 6'h20;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("add_state%0d", i), int'(obs3.state), exp_st[i]);
            chk($sformatf("add_reg_write%0d", i), int'(obs3.reg_write), (i == 3) ? 1 : 0);
            chk($sformatf("add_pc_write%0d", i), int'(obs3.pc_write), (i == 3) ? 1 : 0);
            chk($sformatf("add_busy%0d", i), int'(obs3.busy), (i == 0 || i == 4) ? 0 : 1);
            @(negedge clk);
        end

        // Reset in the second MEM cycle of lw on the MEM_LAT=4 instance.
        sel = 1'b1;
        do_reset();
        op   = 6'h23;
        func = 6'h00;
        ahi  = 22'h000001;
        repeat (4) @(negedge clk);
        #1;
        chk("midmem_state", int'(obs4.state), 3);
        chk("midmem_mem_read", int'(obs4.mem_read), 1);
        reset = 1'b1;
        #1;
        chk("midmem_reset_cycle", int'(obs4), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midmem_after_state", int'(obs4.state), 0);
        chk("midmem_after_strobes", int'({obs4.pc_write, obs4.reg_write, obs4.mem_read,
            obs4.mem_write, obs4.io_read, obs4.io_write, obs4.m2r}), 0);
        op   = 6'h00;
        func = 6'h20;
        run_instr(100, vecs[0]);

        // lw to memory on the MEM_LAT=4 instance: 8 cycles, 4 reads.
        do_reset();
        run_instr(101, '{6'h23, 6'h00, 22'h000001, 0, 0, 8, 1, 1, 4, 0, 0, 0, 1, 9'b0_1_00_0_0_0_0_0});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mc_control32.md
MC_CONTROL32 -- requirements
Module: mc_control32

Interface
REQ-001 SHALL have parameter IO_HIGH_W, default 22: width of the address-high field used for I/O decode.
REQ-002 SHALL have parameter IO_HIGH_VAL, default all-ones of IO_HIGH_W: address-high value that selects I/O space.
REQ-003 SHALL have parameter MEM_LAT, default 1, legal 1..15: data-memory access cycles.
REQ-004 SHALL have one clock and a synchronous active-high reset: clock input 1 (rising edge), then reset input 1 (synchronous, active-high).
REQ-005 SHALL have these ports:
- op  input  6  instruction[31:26]
- func  input  6  instruction[5:0]
- alu_result_high  input  IO_HIGH_W  ALU address high bits
- io_ready  input  1  I/O device completed access
- pc_write, ir_write  output  1  PC update, instruction-register load
- alu_op  output  2  {R/I-format, branch}
- jr, jal, branch, nbranch, reg_dst, alu_src, sftmd  output  1  decoded controls
- reg_write, mem_read, mem_write, io_read, io_write, mem_or_io_to_reg  output  1  phase-gated strobes
- state  output  3  current FSM state
- busy  output  1  high in every state except FETCH

Function
REQ-006 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge.
REQ-007 FETCH SHALL assert ir_write for exactly one cycle, then go to DECODE.
REQ-008 DECODE SHALL register op and func; decoded controls SHALL come from the registered values and stay stable until the next FETCH.
REQ-009 Decode rules:
- R = op 0; I = op[5:3]==001; lw = 0x23; sw = 0x2B; beq = 0x04; bne = 0x05; jal = 0x03; j = 0x02
- jr = R and func 0x08
- sftmd = R and func in {00,02,03,04,06,07}
- alu_src = not R; reg_dst = R; alu_op = {R or I, beq or bne}
REQ-010 EXEC transitions:
- lw/sw: go to MEM
- R (not jr), I, jal: go to WB
- otherwise (beq, bne, j, jr, unknown op): assert pc_write this cycle, go to FETCH
REQ-011 On EXEC->MEM, SHALL latch is_io = (alu_result_high == IO_HIGH_VAL).
REQ-012 MEM, memory (is_io=0):
- hold mem_read (lw) or mem_write (sw) for exactly MEM_LAT cycles, counted by a 4-bit down-counter
- leave MEM after the last cycle
REQ-013 MEM, I/O (is_io=1):
- hold io_read or io_write until io_ready is sampled high; that cycle is the last MEM cycle
- no timeout
REQ-014 On leaving MEM: sw SHALL assert pc_write in the last MEM cycle and go to FETCH; lw SHALL go to WB.
REQ-015 WB SHALL last one cycle and assert reg_write and pc_write; mem_or_io_to_reg SHALL be 1 in WB only for lw; then go to FETCH.
REQ-016 reg_write SHALL never assert for jr, sw, branches, j or unknown ops.
REQ-017 mem_read, mem_write, io_read and io_write SHALL be zero outside MEM; at most one of them SHALL be high in any cycle.
REQ-018 Cycle counts per instruction:
- R/I/jal: 4
- branch/j/jr: 3
- sw to memory: 3+MEM_LAT
- lw to memory: 4+MEM_LAT
- I/O: wait-dependent
REQ-019 io_ready outside MEM SHALL be ignored.

Reset
REQ-020 While reset is high at a rising edge: state=FETCH, the counter, is_io and the op/func registers clear to 0.
REQ-021 Every output except state and busy SHALL be 0 during the reset cycle; state=0 and busy=0.
REQ-022 Reset mid-MEM or mid-WB SHALL drop all strobes in the reset cycle with no pc_write.

Structure
REQ-023 A shared package mc_ctrl_pkg SHALL hold the state encoding, opcode/func constants and the I/O-decode defaults.
REQ-024 A combinational sub-module instr_decode (registered op/func in, REQ-009 controls out) SHALL be instantiated once; the FSM, counter and is_io stay in mc_control32.

Verification
REQ-025 add (op 0, func 0x20) -> states 0,1,2,4,0; reg_write and pc_write high only in the WB cycle; reg_dst=1.
REQ-026 lw (0x23), alu_result_high=0x000001, MEM_LAT=3 -> mem_read high for exactly 3 cycles, then WB with mem_or_io_to_reg=1; total 7 cycles.
REQ-027 sw (0x2B), alu_result_high=0x3FFFFF, io_ready low for 5 MEM cycles then high -> io_write high for 6 cycles, pc_write in the 6th, no reg_write.
REQ-028 jr (op 0, func 0x08) and bne (0x05) -> 3 cycles each, pc_write in EXEC, reg_write never high; alu_op=01 for bne.
REQ-029 Reset asserted in the 2nd MEM cycle of lw with MEM_LAT=4 -> next cycle state=0, all strobes 0; a following add completes normally.
REQ-030 Unknown op 0x3F -> 3-cycle no-op with pc_write only; io_ready pulsed during FETCH has no effect.
